// File: rtl/tb_axi_stream_pkg.sv
// Shared definitions for the AXI-stream protocol monitor: error bit indices
// and packet FSM encoding.
package tb_axi_stream_pkg;

    localparam int ERR_BITS         = 6;
    localparam int ERR_WITHDRAW     = 0;
    localparam int ERR_CHANGE       = 1;
    localparam int ERR_RDY_WITHDRAW = 2;
    localparam int ERR_KEEP         = 3;
    localparam int ERR_PKT_LONG     = 4;
    localparam int ERR_STALL        = 5;

    typedef enum logic {
        PKT_IDLE = 1'b0,
        PKT_IN   = 1'b1
    } pkt_state_t;

endpackage

// File: rtl/tb_sat_counter.sv
// Saturating up-counter with synchronous clear. A clear coinciding with an
// increment leaves the count at 1, so an event in the clear cycle is kept.
module tb_sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= WIDTH'(inc);
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/tb_axi_stream_monitor.sv
// Passive AXI-stream protocol monitor: hold-rule, tkeep, packet-length and
// stall checks reported as sticky flags plus saturating statistics.
//
// state    | meaning
// PKT_IDLE | between packets; next handshake is beat 1 of a new packet
// PKT_IN   | at least one non-last beat of the current packet accepted
module tb_axi_stream_monitor
    import tb_axi_stream_pkg::*;
#(
    parameter int DWIDTH         = 32,
    parameter int CNT_WIDTH      = 32,
    parameter int MAX_PKT_BEATS  = 0,
    parameter int STALL_TIMEOUT  = 1024,
    parameter int CHECK_RECEIVER = 0,
    parameter int CHECK_TKEEP    = 1,
    parameter int STOP_ON_ERROR  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  tready,
    input  logic                  tvalid,
    input  logic [DWIDTH-1:0]     tdata,
    input  logic                  tlast,
    input  logic [DWIDTH/8-1:0]   tkeep,
    output logic [ERR_BITS-1:0]   err_flags,
    output logic                  err_any,
    output logic [CNT_WIDTH-1:0]  err_cnt,
    output logic [CNT_WIDTH-1:0]  beat_cnt,
    output logic [CNT_WIDTH-1:0]  pkt_cnt,
    output logic                  in_packet
);

    localparam int KW   = DWIDTH / 8;
    localparam int PB_W = (MAX_PKT_BEATS > 0) ? $clog2(MAX_PKT_BEATS + 1) : 1;
    localparam int ST_W = (STALL_TIMEOUT > 0) ? $clog2(STALL_TIMEOUT + 1) : 1;

    localparam logic [PB_W-1:0] PB_MAX  = PB_W'(MAX_PKT_BEATS);
    localparam logic [PB_W-1:0] PB_LAST = (MAX_PKT_BEATS > 0) ? PB_W'(MAX_PKT_BEATS - 1) : '0;
    localparam logic [ST_W-1:0] ST_LAST = (STALL_TIMEOUT > 0) ? ST_W'(STALL_TIMEOUT - 1) : '0;

    logic              hs;
    logic              stall;
    logic              prev_tready;
    logic              prev_tvalid;
    logic [DWIDTH-1:0] prev_tdata;
    logic              prev_tlast;
    logic [KW-1:0]     prev_tkeep;
    logic [KW-1:0]     keep_inc;
    logic              keep_last_ok;
    logic [ERR_BITS-1:0] chk;
    pkt_state_t        state;
    logic [PB_W-1:0]   pkt_beats;
    logic [ST_W-1:0]   stall_cnt;

    assign hs    = tvalid & tready;
    assign stall = tvalid & ~tready;

    // A legal last-beat tkeep is a non-empty run of ones from bit 0,
    // i.e. k != 0 and k & (k+1) == 0.
    assign keep_inc     = tkeep + KW'(1);
    assign keep_last_ok = (tkeep != '0) && ((tkeep & keep_inc) == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_tready <= 1'b0;
            prev_tvalid <= 1'b0;
            prev_tdata  <= '0;
            prev_tlast  <= 1'b0;
            prev_tkeep  <= '0;
        end else begin
            prev_tready <= tready;
            prev_tvalid <= tvalid;
            prev_tdata  <= tdata;
            prev_tlast  <= tlast;
            prev_tkeep  <= tkeep;
        end
    end

    always_comb begin
        chk = '0;
        if (prev_tvalid && !prev_tready) begin
            chk[ERR_WITHDRAW] = (tvalid !== 1'b1);
            chk[ERR_CHANGE]   = (tdata !== prev_tdata) || (tlast !== prev_tlast) ||
                                (tkeep !== prev_tkeep);
        end
        if ((CHECK_RECEIVER != 0) && prev_tready && !prev_tvalid) begin
            chk[ERR_RDY_WITHDRAW] = (tready !== 1'b1);
        end
        if ((CHECK_TKEEP != 0) && hs) begin
            chk[ERR_KEEP] = tlast ? !keep_last_ok : (tkeep != '1);
        end
        // pkt_beats counts beats already accepted, so this handshake is beat pkt_beats+1.
        if ((MAX_PKT_BEATS != 0) && hs && !tlast) begin
            chk[ERR_PKT_LONG] = (pkt_beats == PB_LAST);
        end
        if ((STALL_TIMEOUT != 0) && stall) begin
            chk[ERR_STALL] = (stall_cnt == ST_LAST);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= PKT_IDLE;
            in_packet <= 1'b0;
            pkt_beats <= '0;
        end else if (hs) begin
            if (tlast) begin
                state     <= PKT_IDLE;
                in_packet <= 1'b0;
                pkt_beats <= '0;
            end else begin
                state     <= PKT_IN;
                in_packet <= 1'b1;
                if (state == PKT_IDLE) begin
                    pkt_beats <= PB_W'(1);
                end else if (pkt_beats != PB_MAX) begin
                    pkt_beats <= pkt_beats + PB_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_flags <= '0;
        end else if (clr) begin
            err_flags <= chk;
        end else begin
            err_flags <= err_flags | chk;
        end
    end

    assign err_any = |err_flags;

    tb_sat_counter #(.WIDTH(CNT_WIDTH)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .inc   (|chk),
        .count (err_cnt)
    );

    tb_sat_counter #(.WIDTH(CNT_WIDTH)) u_beat_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .inc   (hs),
        .count (beat_cnt)
    );

    tb_sat_counter #(.WIDTH(CNT_WIDTH)) u_pkt_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .inc   (hs & tlast),
        .count (pkt_cnt)
    );

    // Stall run length; any non-stall cycle restarts the episode.
    tb_sat_counter #(.WIDTH(ST_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (~stall),
        .inc   (stall),
        .count (stall_cnt)
    );

    if (STOP_ON_ERROR != 0) begin : g_stop
        always @(posedge clk) begin
            if (!rst && (chk != '0)) begin
                $display("%m: protocol error at %0t:%s%s%s%s%s%s", $time,
                         chk[ERR_WITHDRAW]     ? " WITHDRAW"     : "",
                         chk[ERR_CHANGE]       ? " CHANGE"       : "",
                         chk[ERR_RDY_WITHDRAW] ? " RDY_WITHDRAW" : "",
                         chk[ERR_KEEP]         ? " KEEP"         : "",
                         chk[ERR_PKT_LONG]     ? " PKT_LONG"     : "",
                         chk[ERR_STALL]        ? " STALL"        : "");
                $stop;
            end
        end
    end

endmodule

// File: tb/tb_tb_axi_stream_monitor.sv
// Directed bench for the AXI-stream monitor: legal traffic, each check,
// clear/error overlap and asynchronous reset mid-packet.
module tb_tb_axi_stream_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic        tready;
    logic        tvalid;
    logic [31:0] tdata;
    logic        tlast;
    logic [3:0]  tkeep;
    logic [5:0]  err_flags;
    logic        err_any;
    logic [31:0] err_cnt;
    logic [31:0] beat_cnt;
    logic [31:0] pkt_cnt;
    logic        in_packet;

    int n_assert = 0;
    int n_fail   = 0;
    int pi       = 0;
    logic [15:0] rdy_pat = 16'b1011_0110_1101_0011;

    tb_axi_stream_monitor #(
        .DWIDTH         (32),
        .CNT_WIDTH      (32),
        .MAX_PKT_BEATS  (4),
        .STALL_TIMEOUT  (8),
        .CHECK_RECEIVER (1),
        .CHECK_TKEEP    (1),
        .STOP_ON_ERROR  (0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .tready    (tready),
        .tvalid    (tvalid),
        .tdata     (tdata),
        .tlast     (tlast),
        .tkeep     (tkeep),
        .err_flags (err_flags),
        .err_any   (err_any),
        .err_cnt   (err_cnt),
        .beat_cnt  (beat_cnt),
        .pkt_cnt   (pkt_cnt),
        .in_packet (in_packet)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        tvalid = 1'b0;
        tready = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_clr();
        tvalid = 1'b0;
        tready = 1'b0;
        clr    = 1'b1;
        @(negedge clk);
        clr    = 1'b0;
    endtask

    task automatic hs_beat(input logic [31:0] d, input logic l, input logic [3:0] k);
        tvalid = 1'b1;
        tready = 1'b1;
        tdata  = d;
        tlast  = l;
        tkeep  = k;
        @(negedge clk);
    endtask

    // Beat held stable while tready follows a fixed pattern until accepted.
    task automatic stream_beat(input logic [31:0] d, input logic l, input logic [3:0] k);
        logic took;
        int   guard;
        tvalid = 1'b1;
        tdata  = d;
        tlast  = l;
        tkeep  = k;
        took   = 1'b0;
        guard  = 0;
        while (!took && guard < 32) begin
            tready = rdy_pat[pi];
            took   = rdy_pat[pi];
            pi     = (pi + 1) % 16;
            guard++;
            @(negedge clk);
        end
        if (!took) check("stream_beat_timeout", 32'(took), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; clr = 1'b0; tready = 1'b0; tvalid = 1'b0;
        tdata = '0; tlast = 1'b0; tkeep = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_flags",   32'(err_flags), 32'd0);
        check("rst_errcnt",  err_cnt,        32'd0);
        check("rst_beat",    beat_cnt,       32'd0);
        check("rst_pkt",     pkt_cnt,        32'd0);
        check("rst_inpkt",   32'(in_packet), 32'd0);
        idle();

        // legal traffic: 3 packets x 4 beats with a stalling receiver
        for (int p = 0; p < 3; p++) begin
            for (int b = 0; b < 4; b++) begin
                stream_beat(32'h1000_0000 + 32'(p * 16 + b), (b == 3), 4'hF);
                if (p == 0 && b == 0) check("legal_inpkt_first", 32'(in_packet), 32'd1);
            end
        end
        check("legal_errany", 32'(err_any),   32'd0);
        check("legal_beat",   beat_cnt,       32'd12);
        check("legal_pkt",    pkt_cnt,        32'd3);
        check("legal_inpkt",  32'(in_packet), 32'd0);
        idle();
        check("legal_idle_errany", 32'(err_any), 32'd0);

        // sender withdraws tvalid after a stalled cycle
        do_clr();
        tvalid = 1'b1; tready = 1'b0; tdata = 32'hA5A5_0001; tlast = 1'b1; tkeep = 4'hF;
        @(negedge clk);
        check("withdraw_pre", 32'(err_flags), 32'd0);
        tvalid = 1'b0;
        @(negedge clk);
        check("withdraw_flags",  32'(err_flags), 32'h01);
        check("withdraw_errcnt", err_cnt,        32'd1);

        // sender changes tdata while stalled
        do_clr();
        tvalid = 1'b1; tready = 1'b0; tdata = 32'hA5A5_0002; tlast = 1'b1; tkeep = 4'hF;
        @(negedge clk);
        tdata = 32'hA5A5_0003;
        @(negedge clk);
        check("change_flags",  32'(err_flags), 32'h02);
        check("change_errcnt", err_cnt,        32'd1);
        tready = 1'b1;
        @(negedge clk);
        check("change_hs_errcnt", err_cnt, 32'd1);
        check("change_hs_pkt",    pkt_cnt, 32'd1);
        idle();

        // receiver withdraws tready before any valid
        do_clr();
        tvalid = 1'b0; tready = 1'b1;
        @(negedge clk);
        check("rdy_pre", 32'(err_flags), 32'd0);
        tready = 1'b0;
        @(negedge clk);
        check("rdy_flags", 32'(err_flags), 32'h04);

        // tkeep legality
        do_clr();
        hs_beat(32'hB000_0001, 1'b0, 4'h7);
        check("keep_mid_flags", 32'(err_flags), 32'h08);
        check("keep_mid_inpkt", 32'(in_packet), 32'd1);
        hs_beat(32'hB000_0002, 1'b1, 4'h5);
        check("keep_last5_errcnt", err_cnt,        32'd2);
        check("keep_last5_inpkt",  32'(in_packet), 32'd0);
        do_clr();
        hs_beat(32'hB000_0003, 1'b1, 4'h3);
        check("keep_last3_flags", 32'(err_flags), 32'd0);
        check("keep_last3_pkt",   pkt_cnt,        32'd1);

        // over-long packet: 6 beats against a 4-beat limit
        do_clr();
        for (int i = 1; i <= 6; i++) begin
            hs_beat(32'hC000_0000 + 32'(i), (i == 6), 4'hF);
            if (i == 3) check("long_b3_flags", 32'(err_flags), 32'd0);
            if (i == 4) check("long_b4_flags", 32'(err_flags), 32'h10);
        end
        check("long_once_errcnt", err_cnt,        32'd1);
        check("long_pkt",         pkt_cnt,        32'd1);
        check("long_beat",        beat_cnt,       32'd6);
        check("long_inpkt",       32'(in_packet), 32'd0);
        for (int i = 1; i <= 4; i++) hs_beat(32'hC100_0000 + 32'(i), (i == 4), 4'hF);
        check("long_next_ok_errcnt", err_cnt, 32'd1);

        // stall timeout after 8 cycles, counted once per episode
        do_clr();
        tvalid = 1'b1; tready = 1'b0; tdata = 32'hD000_0001; tlast = 1'b1; tkeep = 4'hF;
        repeat (7) @(negedge clk);
        check("stall_7_flags", 32'(err_flags), 32'd0);
        @(negedge clk);
        check("stall_8_flags",  32'(err_flags), 32'h20);
        check("stall_8_errcnt", err_cnt,        32'd1);
        repeat (4) @(negedge clk);
        check("stall_hold_errcnt", err_cnt, 32'd1);
        tready = 1'b1;
        @(negedge clk);
        idle();

        // error in the clr cycle replaces older flags
        hs_beat(32'hE000_0001, 1'b1, 4'h0);
        check("clrerr_pre_flags",  32'(err_flags), 32'h28);
        check("clrerr_pre_errcnt", err_cnt,        32'd2);
        tvalid = 1'b1; tready = 1'b0; tdata = 32'hE000_0002; tlast = 1'b1; tkeep = 4'hF;
        @(negedge clk);
        tvalid = 1'b0; clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clrerr_flags",  32'(err_flags), 32'h01);
        check("clrerr_errcnt", err_cnt,        32'd1);
        check("clrerr_beat",   beat_cnt,       32'd0);
        idle();

        // asynchronous reset mid-packet and mid-stall
        hs_beat(32'hF000_0001, 1'b0, 4'hF);
        hs_beat(32'hF000_0002, 1'b0, 4'hF);
        check("rstmid_pre_inpkt", 32'(in_packet), 32'd1);
        tready = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rstmid_inpkt",  32'(in_packet), 32'd0);
        check("rstmid_beat",   beat_cnt,       32'd0);
        check("rstmid_pkt",    pkt_cnt,        32'd0);
        check("rstmid_errcnt", err_cnt,        32'd0);
        check("rstmid_flags",  32'(err_flags), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        hs_beat(32'hF000_0003, 1'b1, 4'hF);
        check("rstpost_pkt",   pkt_cnt,        32'd1);
        check("rstpost_beat",  beat_cnt,       32'd1);
        check("rstpost_inpkt", 32'(in_packet), 32'd0);
        check("rstpost_flags", 32'(err_flags), 32'd0);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
